// File: rtl/fetch_unit.sv
// fetch_unit: PC register, next-PC selection and IF/ID pipeline register.
// Feeds a combinational-read instruction memory; decode consumes IF/ID.
module fetch_unit #(
  parameter int            N        = 32,
  parameter logic [N-1:0]  RESET_PC = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall,
  input  logic         flush,
  input  logic         branch_taken,
  input  logic [N-1:0] branch_target,
  input  logic         jump,
  input  logic [25:0]  jump_index,
  output logic [N-1:0] imem_addr,
  input  logic [N-1:0] imem_instr,
  output logic [N-1:0] if_id_instr,
  output logic [N-1:0] if_id_pc4,
  output logic         if_id_valid,
  output logic [31:0]  fetch_count,
  output logic         align_err
);

  typedef struct packed {
    logic [N-1:0] instr;
    logic [N-1:0] pc4;
    logic         valid;
  } if_id_t;

  localparam if_id_t BUBBLE = '{instr: '0, pc4: '0, valid: 1'b0};

  logic [N-1:0] pc;
  logic [N-1:0] pc4;
  logic [N-1:0] pc_next;
  logic [N-1:0] jump_target;
  logic [N-1:0] redirect_raw;
  logic [N-1:0] redirect_pc;
  logic         redirect;
  logic         misaligned;
  logic         load;
  logic         sel_branch;
  logic         sel_jump;
  logic         sel_hold;
  logic         sel_seq;
  if_id_t       if_id;

  assign imem_addr   = pc;
  assign pc4         = pc + N'(4);
  assign redirect    = branch_taken | jump;

  // Pseudo-direct target takes its region bits from the
  // instruction sitting in ID, not from the fetch PC.
  assign jump_target = {if_id.pc4[N-1:28], jump_index, 2'b00};

  assign redirect_raw = branch_taken ? branch_target : jump_target;
  assign redirect_pc  = {redirect_raw[N-1:2], 2'b00};
  assign misaligned   = redirect & (|redirect_raw[1:0]);

  // One-hot select so the priority is explicit and exclusive.
  assign sel_branch = branch_taken;
  assign sel_jump   = jump & ~branch_taken;
  assign sel_hold   = stall & ~redirect;
  assign sel_seq    = ~stall & ~redirect;

  // New instruction enters IF/ID only on a clean, unstalled cycle.
  assign load = ~redirect & ~flush & ~stall;

  // Next-PC mux.
  always_comb begin
    pc_next = pc4;
    unique case (1'b1)
      sel_branch: pc_next = redirect_pc;
      sel_jump:   pc_next = redirect_pc;
      sel_hold:   pc_next = pc;
      sel_seq:    pc_next = pc4;
      default:    pc_next = pc4;
    endcase
  end

  // Program counter.
  always_ff @(posedge clk) begin
    if (rst) pc <= RESET_PC;
    else     pc <= pc_next;
  end

  // IF/ID register: bubble on redirect/flush, hold on stall.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id <= BUBBLE;
    end else if (redirect | flush) begin
      if_id <= BUBBLE;
    end else if (!stall) begin
      if_id.instr <= imem_instr;
      if_id.pc4   <= pc4;
      if_id.valid <= 1'b1;
    end
  end

  // Count of valid instructions handed to decode.
  always_ff @(posedge clk) begin
    if (rst)       fetch_count <= '0;
    else if (load) fetch_count <= fetch_count + 32'd1;
  end

  // Sticky misaligned-redirect flag.
  always_ff @(posedge clk) begin
    if (rst)             align_err <= 1'b0;
    else if (misaligned) align_err <= 1'b1;
  end

  assign if_id_instr = if_id.instr;
  assign if_id_pc4   = if_id.pc4;
  assign if_id_valid = if_id.valid;

endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: directed scenarios plus randomized run
// checked against a cycle-level behavioural model.
module tb_fetch_unit;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst, stall, flush;
  logic        branch_taken, jump;
  logic [31:0] branch_target;
  logic [25:0] jump_index;
  logic [31:0] imem_addr, imem_instr;
  logic [31:0] if_id_instr, if_id_pc4;
  logic        if_id_valid, align_err;
  logic [31:0] fetch_count;

  int checks = 0;
  int errors = 0;

  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_err;

  always #5 clk = ~clk;

  fetch_unit #(.N(32), .RESET_PC(RST_PC)) dut (
    .clk(clk), .rst(rst), .stall(stall), .flush(flush),
    .branch_taken(branch_taken), .branch_target(branch_target),
    .jump(jump), .jump_index(jump_index),
    .imem_addr(imem_addr), .imem_instr(imem_instr),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .fetch_count(fetch_count),
    .align_err(align_err)
  );

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h2008_0005;
      32'h4:   return 32'h2009_0007;
      32'h8:   return 32'h0109_5020;
      default: return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
    endcase
  endfunction

  always_comb imem_instr = mem_word(imem_addr);

  // Advance the model by one clock from the current inputs, then clock the DUT.
  task automatic step();
    logic [31:0] tgt, npc;
    if (rst) begin
      m_pc = RST_PC; m_instr = 0; m_pc4 = 0;
      m_valid = 0; m_cnt = 0; m_err = 0;
    end else begin
      if (branch_taken) tgt = branch_target;
      else tgt = {m_pc4[31:28], jump_index, 2'b00};
      if (branch_taken || jump) begin
        if (tgt % 4 != 0) m_err = 1;
        npc = tgt - (tgt % 4);
      end else if (stall) npc = m_pc;
      else npc = m_pc + 4;
      if (branch_taken || jump || flush) begin
        m_instr = 0; m_pc4 = 0; m_valid = 0;
      end else if (!stall) begin
        m_instr = mem_word(m_pc);
        m_pc4 = m_pc + 4;
        m_valid = 1;
        m_cnt = m_cnt + 1;
      end
      m_pc = npc;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rst = 0; stall = 0; flush = 0;
    branch_taken = 0; jump = 0;
    branch_target = 0; jump_index = 0;
  endtask

  task automatic test_reset();
    idle(); rst = 1;
    step(); step();
    checks++;
    if (imem_addr !== 32'h0) begin
      errors++; $display("FAIL reset_addr got %h exp 0", imem_addr);
    end
    checks++;
    if ({if_id_instr, if_id_pc4, if_id_valid} !== 65'h0) begin
      errors++;
      $display("FAIL reset_ifid got %h/%h/%b exp 0",
               if_id_instr, if_id_pc4, if_id_valid);
    end
    checks++;
    if (fetch_count !== 0 || align_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt got %0d/%b exp 0/0", fetch_count, align_err);
    end
  endtask

  task automatic test_stream();
    logic [31:0] exp_i [3];
    exp_i[0] = 32'h2008_0005;
    exp_i[1] = 32'h2009_0007;
    exp_i[2] = 32'h0109_5020;
    idle();
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if (if_id_instr !== exp_i[k] || if_id_pc4 !== 32'(4*(k+1))
          || if_id_valid !== 1'b1 || imem_addr !== 32'(4*(k+1))) begin
        errors++;
        $display("FAIL stream%0d got %h/%h/%b addr %h exp %h/%h/1",
                 k, if_id_instr, if_id_pc4, if_id_valid, imem_addr,
                 exp_i[k], 32'(4*(k+1)));
      end
    end
    checks++;
    if (fetch_count !== 3) begin
      errors++; $display("FAIL stream_cnt got %0d exp 3", fetch_count);
    end
  endtask

  task automatic test_stall();
    idle(); rst = 1; step(); step();
    rst = 0; step(); step();
    stall = 1;
    for (int k = 0; k < 2; k++) begin
      step();
      checks++;
      if (imem_addr !== 32'h8 || if_id_instr !== 32'h2009_0007
          || if_id_pc4 !== 32'h8 || fetch_count !== 2) begin
        errors++;
        $display("FAIL stall%0d got addr %h %h/%h cnt %0d exp 8 20090007/8 2",
                 k, imem_addr, if_id_instr, if_id_pc4, fetch_count);
      end
    end
    stall = 0; step();
    checks++;
    if (if_id_instr !== 32'h0109_5020 || if_id_pc4 !== 32'hC
        || imem_addr !== 32'hC) begin
      errors++;
      $display("FAIL stall_resume got %h/%h addr %h exp 01095020/c addr c",
               if_id_instr, if_id_pc4, imem_addr);
    end
  endtask

  task automatic test_branch_stall();
    idle(); step();
    stall = 1; branch_taken = 1; branch_target = 32'h40;
    step();
    checks++;
    if (imem_addr !== 32'h40 || if_id_valid !== 1'b0 || if_id_instr !== 0) begin
      errors++;
      $display("FAIL br_stall got addr %h v %b i %h exp 40/0/0",
               imem_addr, if_id_valid, if_id_instr);
    end
    idle(); step();
    checks++;
    if (if_id_instr !== mem_word(32'h40) || if_id_pc4 !== 32'h44
        || if_id_valid !== 1'b1) begin
      errors++;
      $display("FAIL br_land got %h/%h exp %h/44",
               if_id_instr, if_id_pc4, mem_word(32'h40));
    end
  endtask

  task automatic test_jump();
    idle(); branch_taken = 1; branch_target = 32'h0040_0004;
    step(); idle(); step();
    jump = 1; jump_index = 26'h000_0010;
    step();
    checks++;
    if (imem_addr !== 32'h40 || if_id_valid !== 1'b0 || if_id_instr !== 0) begin
      errors++;
      $display("FAIL jump got addr %h v %b exp 40/0", imem_addr, if_id_valid);
    end
    idle(); branch_taken = 1; branch_target = 32'hA000_0000;
    step(); idle(); step();
    jump = 1; jump_index = 26'h000_0020;
    step();
    checks++;
    if (imem_addr !== 32'hA000_0080) begin
      errors++;
      $display("FAIL jump_region got %h exp a0000080", imem_addr);
    end
    idle();
  endtask

  task automatic test_misalign_wrap();
    idle(); branch_taken = 1; branch_target = 32'h22;
    step();
    checks++;
    if (imem_addr !== 32'h20 || align_err !== 1'b1) begin
      errors++;
      $display("FAIL misalign got %h/%b exp 20/1", imem_addr, align_err);
    end
    idle(); step(); step();
    checks++;
    if (align_err !== 1'b1) begin
      errors++; $display("FAIL sticky got %b exp 1", align_err);
    end
    branch_taken = 1; branch_target = 32'hFFFF_FFFC;
    step(); idle(); step();
    checks++;
    if (imem_addr !== 32'h0 || if_id_pc4 !== 32'h0 || if_id_valid !== 1'b1
        || if_id_instr !== mem_word(32'hFFFF_FFFC)) begin
      errors++;
      $display("FAIL wrap got addr %h pc4 %h v %b exp 0/0/1",
               imem_addr, if_id_pc4, if_id_valid);
    end
  endtask

  task automatic test_reset_mid();
    idle(); step(); step();
    rst = 1; branch_taken = 1; flush = 1; branch_target = 32'h81;
    step();
    checks++;
    if (imem_addr !== RST_PC || if_id_instr !== 0 || if_id_pc4 !== 0
        || if_id_valid !== 0 || fetch_count !== 0 || align_err !== 0) begin
      errors++;
      $display("FAIL reset_mid got addr %h %h/%h/%b cnt %0d err %b exp all 0",
               imem_addr, if_id_instr, if_id_pc4, if_id_valid,
               fetch_count, align_err);
    end
    idle();
  endtask

  task automatic test_random();
    for (int c = 0; c < 400; c++) begin
      rst = ($urandom_range(0, 59) == 0);
      stall = ($urandom_range(0, 3) == 0);
      flush = ($urandom_range(0, 7) == 0);
      branch_taken = ($urandom_range(0, 7) == 0);
      jump = ($urandom_range(0, 7) == 0);
      branch_target = $urandom;
      if ($urandom_range(0, 1) == 0) branch_target[1:0] = 2'b00;
      if ($urandom_range(0, 9) == 0) branch_target = 32'hFFFF_FFF0;
      jump_index = 26'($urandom);
      step();
      checks++;
      if (imem_addr !== m_pc || if_id_instr !== m_instr
          || if_id_pc4 !== m_pc4 || if_id_valid !== m_valid
          || fetch_count !== m_cnt || align_err !== m_err) begin
        errors++;
        $display("FAIL rand%0d got %h %h/%h/%b %0d %b exp %h %h/%h/%b %0d %b",
                 c, imem_addr, if_id_instr, if_id_pc4, if_id_valid,
                 fetch_count, align_err, m_pc, m_instr, m_pc4,
                 m_valid, m_cnt, m_err);
      end
    end
    idle();
  endtask

  initial begin
    idle();
    #1;
    test_reset();
    test_stream();
    test_stall();
    test_branch_stall();
    test_jump();
    test_misalign_wrap();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
